mem_access_unit: RTL and testbench

// - Load/store sequencer between the processor control path and data_memory (byte-wide read port, write_en/addr/data_in).
// - Accepts one load or store request at a time and splits it into byte accesses, little-endian (low byte at addr).
// - For word loads, assembles a 16-bit result from two byte reads; for stores, issues one or two byte writes.
// - Signals completion to the core with a one-cycle done pulse.

---
 rtl/mau_pkg.sv | 18 +
 rtl/mau_lat_counter.sv | 34 +++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the load/store sequencer: FSM encoding and read-latency bounds.
package mau_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } mau_state_e;

  // Supported data_memory read latencies; the wait counter is sized for the maximum.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int CNT_W      = 2;

endpackage

// File: rtl/mau_lat_counter.sv
// Read wait counter: reloaded when a byte read address is issued, and reports
// when the read data has had RD_LAT cycles to arrive.
module mau_lat_counter
  import mau_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on a new read, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CNT_W'(RD_LAT - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Zero means the current cycle is the last one of the read wait.
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: splits one core request into little-endian byte
// accesses on data_memory, assembles word loads, pulses done on completion.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1   // valid range RD_LAT_MIN..RD_LAT_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [7:0]        mem_data_out
);

  mau_state_e        state_q;
  logic              busy_q, done_q, we_q, word_q;
  logic [ADDR_W-1:0] base_q, maddr_q;
  logic [DATA_W-1:0] mdin_q, rdata_q;
  logic [7:0]        whi_q, lo_q;
  logic              lat_load, lat_expired;
  logic [ADDR_W-1:0] next_addr;

  // addr + 1 wraps naturally at the top of the address space.
  assign next_addr = base_q + ADDR_W'(1);

  // The wait counter restarts whenever a byte read address goes out.
  assign lat_load = ((state_q == S_IDLE) && req && !req_we) ||
                    ((state_q == S_RD_LO) && lat_expired && word_q);

  mau_lat_counter #(.RD_LAT(RD_LAT)) u_lat (
    .clk       (clk),
    .rst       (rst),
    .load_i    (lat_load),
    .expired_o (lat_expired)
  );

  // Sequencer FSM with registered memory-side and core-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      base_q  <= '0;
      maddr_q <= '0;
      mdin_q  <= '0;
      rdata_q <= '0;
      whi_q   <= '0;
      lo_q    <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            busy_q  <= 1'b1;
            word_q  <= req_word;
            base_q  <= req_addr;
            maddr_q <= req_addr;
            whi_q   <= req_wdata[15:8];
            if (req_we) begin
              state_q <= S_WR_LO;
              mdin_q  <= DATA_W'(req_wdata[7:0]);
              we_q    <= 1'b1;
            end else begin
              state_q <= S_RD_LO;
            end
          end
        end
        S_RD_LO: begin
          if (lat_expired) begin
            if (word_q) begin
              lo_q    <= mem_data_out;
              maddr_q <= next_addr;
              state_q <= S_RD_HI;
            end else begin
              rdata_q <= DATA_W'(mem_data_out);
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RD_HI: begin
          if (lat_expired) begin
            rdata_q <= DATA_W'({mem_data_out, lo_q});
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_WR_LO: begin
          if (word_q) begin
            maddr_q <= next_addr;
            mdin_q  <= DATA_W'(whi_q);
            we_q    <= 1'b1;
            state_q <= S_WR_HI;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_WR_HI: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        // A req seen here is dropped; it is only sampled again in IDLE.
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rdata        = rdata_q;
  assign mem_write_en = we_q;
  assign mem_addr     = maddr_q;
  assign mem_data_in  = mdin_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit against a byte-wide data_memory model (RD_LAT=1).
module tb_mem_access_unit;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst, req, req_we, req_word;
  logic [15:0] req_addr, req_wdata;
  logic        busy, done, mem_write_en;
  logic [15:0] rdata, mem_addr, mem_data_in;
  logic [7:0]  mem_data_out;

  always #50 clk = ~clk;

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_we       (req_we),
    .req_word     (req_word),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // data_memory: synchronous byte write; read data is sampled by the DUT
  // RD_LAT(=1) edge after the address is presented.
  logic [7:0] mem [0:65535] = '{default: 8'h00};
  always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_data_in[7:0];
  assign mem_data_out = mem[mem_addr];

  // Monitors: every write cycle ({addr, byte}) and every done pulse.
  logic [23:0] wlog[$];
  int          n_done = 0;
  always @(posedge clk) if (mem_write_en) wlog.push_back({mem_addr, mem_data_in[7:0]});
  always @(posedge clk) if (done) n_done++;

  typedef struct {
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;  // loads only
  } vec_t;

  vec_t        vecs[12];
  logic [23:0] wexp[$];
  logic [15:0] rq[$];
  logic [15:0] last_rd = 16'h0000;
  int          wr_idx = 0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drain the expected-write queue against the monitored writes.
  task automatic check_writes(input string name);
    logic [23:0] e;
    int exp_total;
    while (wexp.size() > 0) begin
      e = wexp.pop_front();
      if (wr_idx < wlog.size()) chk($sformatf("%s_wr%0d", name, wr_idx), wlog[wr_idx], e);
      else                      chk($sformatf("%s_wr%0d_missing", name, wr_idx), 32'd0, 32'd1);
      wr_idx++;
    end
    exp_total = wr_idx;
    chk($sformatf("%s_wrcount", name), wlog.size(), exp_total);
    wr_idx = wlog.size();
  endtask

  // Wait (bounded) for done; returns cycles counted from the accepting edge.
  task automatic wait_done(output bit got, inout int lat);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    logic [15:0] a1, er;
    int  lat, nb, exp_lat;
    bit  got;
    string nm;
    nm = $sformatf("op%0d", idx);
    nb = v.word ? 2 : 1;
    @(negedge clk);
    req = 1'b1; req_we = v.we; req_word = v.word; req_addr = v.addr; req_wdata = v.wdata;
    if (v.we) begin
      wexp.push_back({v.addr, v.wdata[7:0]});
      if (v.word) begin a1 = v.addr + 16'd1; wexp.push_back({a1, v.wdata[15:8]}); end
      rq.push_back(last_rd);               // stores leave rdata alone
      exp_lat = nb + 1;
    end else begin
      rq.push_back(v.exp_rdata);
      last_rd = v.exp_rdata;
      exp_lat = RD_LAT * nb + 1;
    end
    @(posedge clk); lat = 1;
    @(negedge clk); req = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    wait_done(got, lat);
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_busy_at_done"}, busy, 0);
    er = rq.pop_front();
    chk({nm, "_rdata"}, rdata, er);
    @(negedge clk);
    chk({nm, "_done_pulse_1cyc"}, done, 0);
    check_writes(nm);
  endtask

  initial begin
    bit got;
    int lat, d0;

    vecs[0]  = '{1'b1, 1'b0, 16'h0002, 16'h0019, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0019};
    vecs[2]  = '{1'b1, 1'b1, 16'h0005, 16'hA532, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h0005, 16'h0000, 16'hA532};
    vecs[4]  = '{1'b0, 1'b0, 16'h0006, 16'h0000, 16'h00A5};
    vecs[5]  = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0012};
    vecs[8]  = '{1'b1, 1'b0, 16'h0100, 16'h77CC, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 16'h0100, 16'h0000, 16'h00CC};
    vecs[10] = '{1'b1, 1'b0, 16'h0003, 16'h5A5A, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 16'h5A19};

    // Reset with a store request held high the whole time.
    rst = 1'b1; req = 1'b1; req_we = 1'b1; req_word = 1'b1;
    req_addr = 16'h0010; req_wdata = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_write_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_data_in, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_no_writes", wlog.size(), 0);
    rst = 1'b0; req = 1'b0;

    for (int i = 0; i < 12; i++) run_op(i, vecs[i]);
    chk("mem_ffff", mem[16'hFFFF], 8'h34);
    chk("mem_0000", mem[16'h0000], 8'h12);

    // req while busy and req in the DONE cycle are both dropped.
    d0 = n_done;
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_word = 1'b1; req_addr = 16'h0040; req_wdata = 16'hBEEF;
    @(posedge clk); lat = 1;
    @(negedge clk);
    req_word = 1'b0; req_addr = 16'h0050; req_wdata = 16'h00DD;   // lands in WR_LO
    @(negedge clk); req = 1'b0;
    wait_done(got, lat);
    chk("ign_done_seen", got, 1);
    req = 1'b1; req_addr = 16'h0060; req_wdata = 16'h00EE;        // lands in DONE
    @(negedge clk); req = 1'b0;
    repeat (6) @(negedge clk);
    chk("ign_single_done", n_done - d0, 1);
    chk("ign_mem50", mem[16'h0050], 8'h00);
    chk("ign_mem60", mem[16'h0060], 8'h00);
    chk("ign_busy", busy, 0);
    chk("ign_rdata_kept", rdata, last_rd);
    wexp.push_back({16'h0040, 8'hEF});
    wexp.push_back({16'h0041, 8'hBE});
    check_writes("ign");

    // Reset in WR_LO of a word store: high byte never written, no done.
    d0 = n_done;
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_word = 1'b1; req_addr = 16'h0080; req_wdata = 16'hCAFE;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    chk("mid_wrlo_we", mem_write_en, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_we", mem_write_en, 0);
    chk("mid_done", done, 0);
    repeat (5) @(negedge clk);
    chk("mid_no_done", n_done - d0, 0);
    chk("mid_mem81", mem[16'h0081], 8'h00);
    chk("mid_mem80", mem[16'h0080], 8'hFE);
    wexp.push_back({16'h0080, 8'hFE});
    check_writes("mid");
    last_rd = 16'h0000;   // reset cleared rdata

    // Unit is back in IDLE and fully functional.
    run_op(20, '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF});
    run_op(21, '{1'b0, 1'b0, 16'h0080, 16'h0000, 16'h00FE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
